// File: rtl/sprite_sched_pkg.sv
// Shared types for the sprite motion scheduler: per-slot state record, FSM states
// and the axis-limit helper.
package sprite_sched_pkg;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       x_dir;
    logic       y_dir;
    logic       en;
    logic [1:0] period;
    logic [1:0] fcnt;
  } sprite_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sched_state_e;

  // Largest legal top-left coordinate so the sprite stays inside the window.
  function automatic logic [7:0] axis_max(input int window, input int sprite);
    return 8'(window - sprite);
  endfunction

endpackage

// File: rtl/sprite_step.sv
// Single-axis bounce step: moves one pixel in the current direction and reflects
// at 0 and max_pos. Positions at or past max_pos with dir 0 are pulled back inside.
module sprite_step
  import sprite_sched_pkg::*;
(
  input  logic [7:0] pos,
  input  logic       dir,
  input  logic [7:0] max_pos,
  output logic [7:0] next_pos,
  output logic       next_dir
);

  always_comb begin
    next_pos = pos;
    next_dir = dir;
    if (!dir) begin
      if (pos >= max_pos) begin
        next_pos = max_pos - 8'd1;
        next_dir = 1'b1;
      end else begin
        next_pos = pos + 8'd1;
        next_dir = (pos == max_pos - 8'd1);
      end
    end else begin
      if (pos == 8'd0) begin
        next_pos = 8'd1;
        next_dir = 1'b0;
      end else begin
        next_pos = pos - 8'd1;
        next_dir = (pos != 8'd1);
      end
    end
  end

endmodule

// File: rtl/sprite_motion_sched.sv
// Per-frame motion scheduler sharing one x/y bounce datapath across all sprite slots.
// Define SPRITE_SCHED_SPEED_EN for per-slot speed dividers; otherwise a global
// every-other-frame divider is used.
module sprite_motion_sched
  import sprite_sched_pkg::*;
#(
  parameter int NUM_SPRITES   = 4,
  parameter int SPRITE_WIDTH  = 16,
  parameter int SPRITE_HEIGHT = 16,
  parameter int WIDTH_SMALL   = 160,
  parameter int HEIGHT_SMALL  = 120
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           next_frame,
  input  logic                           enable_movement,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_SPRITES)-1:0] cfg_idx,
  input  logic [7:0]                     cfg_x,
  input  logic [7:0]                     cfg_y,
  input  logic [1:0]                     cfg_dir,
  input  logic [1:0]                     cfg_period,
  input  logic                           cfg_en,
  input  logic [$clog2(NUM_SPRITES)-1:0] rd_idx,
  output logic [7:0]                     rd_x,
  output logic [7:0]                     rd_y,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overrun
);

  localparam int               IDX_W      = $clog2(NUM_SPRITES);
  localparam logic [7:0]       MAX_X      = axis_max(WIDTH_SMALL, SPRITE_WIDTH);
  localparam logic [7:0]       MAX_Y      = axis_max(HEIGHT_SMALL, SPRITE_HEIGHT);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SPRITES - 1);
  localparam logic [IDX_W:0]   SLOT_LIMIT = (IDX_W + 1)'(NUM_SPRITES);

  if (NUM_SPRITES < 2 || NUM_SPRITES > 16 ||
      WIDTH_SMALL - SPRITE_WIDTH <= 1 || WIDTH_SMALL - SPRITE_WIDTH > 255 ||
      HEIGHT_SMALL - SPRITE_HEIGHT <= 1 || HEIGHT_SMALL - SPRITE_HEIGHT > 255) begin : g_bad_geometry
    $error("sprite_motion_sched: unsupported slot count or window geometry");
  end

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic [7:0]       rd_x_q, rd_x_d, rd_y_q, rd_y_d;
  sprite_state_t    slot_q [NUM_SPRITES];
  sprite_state_t    slot_d [NUM_SPRITES];
`ifndef SPRITE_SCHED_SPEED_EN
  logic             div_q, div_d;
  logic             move_q, move_d;
`endif

  sprite_state_t cur;
  sprite_state_t cfg_slot;
  logic [7:0]    step_x, step_y;
  logic          step_x_dir, step_y_dir;
  logic          step_ok;

  assign cur = slot_q[idx_q];

  sprite_step u_step_x (
    .pos(cur.x), .dir(cur.x_dir), .max_pos(MAX_X),
    .next_pos(step_x), .next_dir(step_x_dir)
  );

  sprite_step u_step_y (
    .pos(cur.y), .dir(cur.y_dir), .max_pos(MAX_Y),
    .next_pos(step_y), .next_dir(step_y_dir)
  );

  always_comb begin
    cfg_slot       = '0;
    cfg_slot.x     = (cfg_x > MAX_X) ? MAX_X : cfg_x;
    cfg_slot.y     = (cfg_y > MAX_Y) ? MAX_Y : cfg_y;
    cfg_slot.x_dir = cfg_dir[0];
    cfg_slot.y_dir = cfg_dir[1];
    cfg_slot.en    = cfg_en;
`ifdef SPRITE_SCHED_SPEED_EN
    cfg_slot.period = cfg_period;
`endif
  end

`ifndef SPRITE_SCHED_SPEED_EN
  logic unused_speed;
  assign unused_speed = ^{cfg_period, cur.period, cur.fcnt};
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
`ifndef SPRITE_SCHED_SPEED_EN
    div_d     = div_q;
    move_d    = move_q;
`endif
    case (state_q)
      IDLE: begin
        if (next_frame || pending_q) begin
          state_d   = SWEEP;
          idx_d     = '0;
          pending_d = 1'b0;
`ifndef SPRITE_SCHED_SPEED_EN
          div_d     = ~div_q;
          move_d    = div_q;
`endif
        end
      end
      SWEEP: begin
        if (idx_q == LAST_IDX) state_d = DONE;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobes outside IDLE are queued once; a second queued strobe is lost.
    if (next_frame && state_q != IDLE) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  always_comb begin
    slot_d  = slot_q;
    step_ok = 1'b0;
    if (state_q == SWEEP && enable_movement && cur.en) begin
`ifdef SPRITE_SCHED_SPEED_EN
      if (cur.fcnt == cur.period) begin
        step_ok             = 1'b1;
        slot_d[idx_q].fcnt  = 2'd0;
      end else begin
        slot_d[idx_q].fcnt  = cur.fcnt + 2'd1;
      end
`else
      step_ok = move_q;
`endif
      if (step_ok) begin
        slot_d[idx_q].x     = step_x;
        slot_d[idx_q].y     = step_y;
        slot_d[idx_q].x_dir = step_x_dir;
        slot_d[idx_q].y_dir = step_y_dir;
      end
    end
    // Applied last so a write to the slot being stepped overrides the step.
    if (cfg_we && ({1'b0, cfg_idx} < SLOT_LIMIT)) slot_d[cfg_idx] = cfg_slot;
  end

  always_comb begin
    rd_x_d = 8'd0;
    rd_y_d = 8'd0;
    if ({1'b0, rd_idx} < SLOT_LIMIT) begin
      rd_x_d = slot_q[rd_idx].x;
      rd_y_d = slot_q[rd_idx].y;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      rd_x_q    <= 8'd0;
      rd_y_q    <= 8'd0;
      for (int i = 0; i < NUM_SPRITES; i++) slot_q[i] <= '0;
`ifndef SPRITE_SCHED_SPEED_EN
      div_q     <= 1'b0;
      move_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      rd_x_q    <= rd_x_d;
      rd_y_q    <= rd_y_d;
      slot_q    <= slot_d;
`ifndef SPRITE_SCHED_SPEED_EN
      div_q     <= div_d;
      move_q    <= move_d;
`endif
    end
  end

  assign rd_x       = rd_x_q;
  assign rd_y       = rd_y_q;
  assign busy       = (state_q == SWEEP);
  assign frame_done = (state_q == DONE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_motion_sched.sv
// Directed bench for sprite_motion_sched; expectations follow SPRITE_SCHED_SPEED_EN
// (per-slot period) or its absence (global every-other-sweep divider).
module tb_sprite_motion_sched;

  localparam int N    = 4;
  localparam int MAXX = 144;
  localparam int MAXY = 104;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       next_frame = 1'b0;
  logic       enable_movement = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [7:0] cfg_x = '0;
  logic [7:0] cfg_y = '0;
  logic [1:0] cfg_dir = '0;
  logic [1:0] cfg_period = '0;
  logic       cfg_en = 1'b0;
  logic [1:0] rd_idx = '0;
  logic [7:0] rd_x, rd_y;
  logic       busy, frame_done, overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_motion_sched dut (
    .clk(clk), .reset(reset), .next_frame(next_frame), .enable_movement(enable_movement),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_dir(cfg_dir),
    .cfg_period(cfg_period), .cfg_en(cfg_en), .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; next_frame = 1'b0; cfg_we = 1'b0; enable_movement = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input int x, input int y, input int dir,
                           input int per, input int en);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_x = 8'(x); cfg_y = 8'(y);
    cfg_dir = 2'(dir); cfg_period = 2'(per); cfg_en = 1'(en);
    tick();
    cfg_we = 1'b0;
  endtask

  // Pulses next_frame, returns cycles from strobe to frame_done, ends back in IDLE.
  task automatic run_frame(output int lat);
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    lat = 1;
    while (frame_done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    tick();
  endtask

  task automatic read_slot(input int idx, output int x, output int y);
    rd_idx = 2'(idx);
    tick();
    x = int'(rd_x);
    y = int'(rd_y);
  endtask

  task automatic prime();
    int lat;
`ifndef SPRITE_SCHED_SPEED_EN
    run_frame(lat);
`endif
  endtask

  // Exactly one movement step with period 0 in either build.
  task automatic step_frame();
    int lat;
    run_frame(lat);
`ifndef SPRITE_SCHED_SPEED_EN
    run_frame(lat);
`endif
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (rd_x !== 8'd0) begin bad++; $display("[TB] FAIL reset_rd_x: got %0d want 0", rd_x); end
    total++; if (rd_y !== 8'd0) begin bad++; $display("[TB] FAIL reset_rd_y: got %0d want 0", rd_y); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_done: got %b want 0", frame_done); end
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
  endtask

  task automatic test_basic_motion();
    int exp_pos [4];
    int lat, x, y;
`ifdef SPRITE_SCHED_SPEED_EN
    exp_pos = '{1, 2, 3, 4};
`else
    exp_pos = '{0, 1, 1, 2};
`endif
    do_reset();
    cfg_write(0, 0, 0, 0, 0, 1);
    for (int f = 0; f < 4; f++) begin
      run_frame(lat);
      read_slot(0, x, y);
      total++; if (lat != N + 1) begin bad++; $display("[TB] FAIL basic_latency f%0d: got %0d want %0d", f, lat, N + 1); end
      total++; if (x != exp_pos[f]) begin bad++; $display("[TB] FAIL basic_x f%0d: got %0d want %0d", f, x, exp_pos[f]); end
      total++; if (y != exp_pos[f]) begin bad++; $display("[TB] FAIL basic_y f%0d: got %0d want %0d", f, y, exp_pos[f]); end
    end
  endtask

  task automatic test_bounce();
    int x, y;
    do_reset();
    prime();
    cfg_write(0, MAXX - 1, 0, 2'b00, 0, 1);
    step_frame(); read_slot(0, x, y);
    total++; if (x != MAXX) begin bad++; $display("[TB] FAIL bounce_hit_max: got %0d want %0d", x, MAXX); end
    step_frame(); read_slot(0, x, y);
    total++; if (x != MAXX - 1) begin bad++; $display("[TB] FAIL bounce_leave_max: got %0d want %0d", x, MAXX - 1); end
    total++; if (y != 2) begin bad++; $display("[TB] FAIL bounce_y_run: got %0d want 2", y); end
    cfg_write(0, 1, MAXY, 2'b01, 0, 1);
    step_frame(); read_slot(0, x, y);
    total++; if (x != 0) begin bad++; $display("[TB] FAIL bounce_hit_zero: got %0d want 0", x); end
    total++; if (y != MAXY - 1) begin bad++; $display("[TB] FAIL bounce_cfg_at_max_y: got %0d want %0d", y, MAXY - 1); end
    step_frame(); read_slot(0, x, y);
    total++; if (x != 1) begin bad++; $display("[TB] FAIL bounce_leave_zero: got %0d want 1", x); end
    total++; if (y != MAXY - 2) begin bad++; $display("[TB] FAIL bounce_forced_dir_y: got %0d want %0d", y, MAXY - 2); end
  endtask

  task automatic test_speed();
    int exp_x [6];
    int lat, x, y;
`ifdef SPRITE_SCHED_SPEED_EN
    exp_x = '{0, 0, 1, 1, 1, 2};
`else
    exp_x = '{0, 1, 1, 2, 2, 3};
`endif
    do_reset();
    cfg_write(0, 0, 0, 0, 2, 1);
    for (int f = 0; f < 6; f++) begin
      run_frame(lat);
      read_slot(0, x, y);
      total++; if (x != exp_x[f]) begin bad++; $display("[TB] FAIL speed_x f%0d: got %0d want %0d", f + 1, x, exp_x[f]); end
    end
  endtask

  task automatic test_back_to_back();
    int cnt, extra, x, y, want_x;
`ifdef SPRITE_SCHED_SPEED_EN
    want_x = 12;
`else
    want_x = 11;
`endif
    do_reset();
    cfg_write(0, 10, 10, 0, 0, 1);
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL b2b_overrun_before: got %b want 0", overrun); end
    next_frame = 1'b1;
    tick(); tick(); tick();
    next_frame = 1'b0;
    cnt = 3;
    while (frame_done !== 1'b1 && cnt < 40) begin tick(); cnt++; end
    total++; if (cnt != N + 1) begin bad++; $display("[TB] FAIL b2b_first_done: got %0d want %0d", cnt, N + 1); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle_gap: got %b want 0", busy); end
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_restart: got %b want 1", busy); end
    cnt = 0;
    while (frame_done !== 1'b1 && cnt < 40) begin tick(); cnt++; end
    total++; if (cnt != N) begin bad++; $display("[TB] FAIL b2b_second_done: got %0d want %0d", cnt, N); end
    total++; if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL b2b_overrun: got %b want 1", overrun); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (frame_done === 1'b1) extra++; end
    total++; if (extra != 0) begin bad++; $display("[TB] FAIL b2b_no_third_sweep: got %0d want 0", extra); end
    read_slot(0, x, y);
    total++; if (x != want_x) begin bad++; $display("[TB] FAIL b2b_motion: got %0d want %0d", x, want_x); end
  endtask

  task automatic test_reset_mid_sweep();
    int dones, x, y;
    cfg_write(1, 50, 60, 0, 0, 1);
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL midrst_busy: got %b want 1", busy); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin if (frame_done === 1'b1) dones++; tick(); end
    total++; if (dones != 0) begin bad++; $display("[TB] FAIL midrst_no_done: got %0d want 0", dones); end
    total++; if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL midrst_overrun: got %b want 0", overrun); end
    for (int s = 0; s < N; s++) begin
      read_slot(s, x, y);
      total++; if (x != 0 || y != 0) begin bad++; $display("[TB] FAIL midrst_slot%0d: got %0d,%0d want 0,0", s, x, y); end
    end
  endtask

  task automatic test_cfg_collision();
    int cnt, x, y;
    do_reset();
    prime();
    cfg_write(3, 20, 20, 0, 0, 1);
    cfg_write(2, 20, 50, 0, 0, 1);
    next_frame = 1'b1;
    tick();
    next_frame = 1'b0;
    tick(); tick();
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_x = 8'd200; cfg_y = 8'd50;
    cfg_dir = 2'b00; cfg_period = 2'd0; cfg_en = 1'b1;
    tick();
    cfg_we = 1'b0;
    cnt = 0;
    while (frame_done !== 1'b1 && cnt < 40) begin tick(); cnt++; end
    tick();
    read_slot(2, x, y);
    total++; if (x != MAXX) begin bad++; $display("[TB] FAIL collide_x_clamped: got %0d want %0d", x, MAXX); end
    total++; if (y != 50) begin bad++; $display("[TB] FAIL collide_y_no_step: got %0d want 50", y); end
    read_slot(3, x, y);
    total++; if (x != 21 || y != 21) begin bad++; $display("[TB] FAIL collide_other_slot: got %0d,%0d want 21,21", x, y); end
    step_frame();
    read_slot(2, x, y);
    total++; if (x != MAXX - 1 || y != 51) begin bad++; $display("[TB] FAIL collide_next_step: got %0d,%0d want %0d,51", x, y, MAXX - 1); end
  endtask

  task automatic test_freeze();
    int lat, x, y;
    do_reset();
    prime();
    cfg_write(0, 30, 40, 0, 0, 1);
    cfg_write(1, 5, 6, 0, 0, 0);
    enable_movement = 1'b0;
    for (int f = 0; f < 4; f++) begin
      run_frame(lat);
      total++; if (lat != N + 1) begin bad++; $display("[TB] FAIL freeze_done f%0d: got %0d want %0d", f, lat, N + 1); end
    end
    read_slot(0, x, y);
    total++; if (x != 30 || y != 40) begin bad++; $display("[TB] FAIL freeze_slot0: got %0d,%0d want 30,40", x, y); end
    enable_movement = 1'b1;
    step_frame();
    read_slot(0, x, y);
    total++; if (x != 31 || y != 41) begin bad++; $display("[TB] FAIL unfreeze_slot0: got %0d,%0d want 31,41", x, y); end
    read_slot(1, x, y);
    total++; if (x != 5 || y != 6) begin bad++; $display("[TB] FAIL slot_disabled: got %0d,%0d want 5,6", x, y); end
  endtask

  initial begin
    test_reset();
    test_basic_motion();
    test_bounce();
    test_speed();
    test_back_to_back();
    test_reset_mid_sweep();
    test_cfg_collision();
    test_freeze();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
